ula_serial_ctrl: RTL

Bit-serial controller that evaluates a WIDTH-bit ALU operation by stepping a single 1-bit ALU slice across the operands, LSB first, one bit per clock. It is the driving side of the slice interface: it generates the INVA/ENA/ENB/F1:F0 controls, feeds operand bits and the rippled carry, and collects result bits and final carry-out. It sits between the datapath control and a 1-bit ALU cell, trading latency for area.

---
 rtl/ula_pkg.sv | 19 +
 rtl/ula_bit_step.sv | 38 +++
 rtl/ula_serial_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared op encodings and FSM state type for the bit-serial ALU controller
package ula_pkg;

  // ALU function select F1:F0
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NOTB = 2'b10,
    OP_ADD  = 2'b11
  } ula_op_e;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } ula_state_e;

endpackage

// File: rtl/ula_bit_step.sv
// rtl/ula_bit_step.sv - combinational 1-bit ALU slice driven by the serial controller
module ula_bit_step
  import ula_pkg::*;
(
  input  logic    inva,
  input  logic    ena,
  input  logic    enb,
  input  ula_op_e op,
  input  logic    a_i,
  input  logic    b_i,
  input  logic    c_in,
  output logic    r,
  output logic    c_out
);

  logic ap;
  logic bp;

  assign ap = (a_i & ena) ^ inva;
  assign bp = b_i & enb;

  // Per-bit function; carry out is only meaningful for ADD and is forced to 0 otherwise
  always_comb begin
    r     = 1'b0;
    c_out = 1'b0;
    case (op)
      OP_AND:  r = ap & bp;
      OP_OR:   r = ap | bp;
      OP_NOTB: r = ~bp;
      OP_ADD: begin
        r     = ap ^ bp ^ c_in;
        c_out = (ap & bp) | (ap & c_in) | (bp & c_in);
      end
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/ula_serial_ctrl.sv
// rtl/ula_serial_ctrl.sv - bit-serial ALU controller, LSB first; optional flags under ULA_SERIAL_FLAGS_EN
module ula_serial_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             inva,
  input  logic             ena,
  input  logic             enb,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  ula_state_e       state;
  ula_op_e          op_sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             inva_sh;
  logic             ena_sh;
  logic             enb_sh;
  logic             carry;
  logic [IW-1:0]    idx;

  logic             bit_r;
  logic             bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // Result bits enter at the MSB so the LSB-first stream lands in order after WIDTH shifts
  assign res_next = {bit_r, r_sh[WIDTH-1:1]};
  assign last_bit = (state == ST_RUN) && (idx == LAST_IDX);

  ula_bit_step u_step (
    .inva  (inva_sh),
    .ena   (ena_sh),
    .enb   (enb_sh),
    .op    (op_sh),
    .a_i   (a_sh[idx]),
    .b_i   (b_sh[idx]),
    .c_in  (carry),
    .r     (bit_r),
    .c_out (bit_c)
  );

  // Control FSM; the edge leaving DONE doubles as an IDLE sampling edge so a held start
  // restarts immediately and back-to-back operations take WIDTH+1 cycles each
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_sh   <= OP_AND;
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      inva_sh <= 1'b0;
      ena_sh  <= 1'b0;
      enb_sh  <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_sh   <= ula_op_e'(op);
            a_sh    <= a;
            b_sh    <= b;
            inva_sh <= inva;
            ena_sh  <= ena;
            enb_sh  <= enb;
            carry   <= (ula_op_e'(op) == OP_ADD) ? cin : 1'b0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sh  <= res_next;
          carry <= bit_c;
          if (last_bit) begin
            result <= res_next;
            cout   <= bit_c;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ULA_SERIAL_FLAGS_EN
  // Status flags captured from the final result on the DONE-entry edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      neg  <= 1'b0;
    end else if (last_bit) begin
      zero <= (res_next == '0);
      neg  <= res_next[WIDTH-1];
    end
  end
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
`endif

endmodule
